// File: rtl/exu_pkg.sv
// Shared EXU definitions: arbiter FSM state encoding, default widths and ALU op encodings.
package exu_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned OP_W_DEF   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } state_t;

   // alu_single operation select, shared with the EXU decoder
   typedef enum logic [1:0] {
      ALU_OP_AND = 2'b00,
      ALU_OP_ADD = 2'b01,
      ALU_OP_OR  = 2'b10,
      ALU_OP_CSR = 2'b11
   } alu_op_t;

endpackage

// File: rtl/exu_rr_arb2.sv
// Two-way round-robin grant; priority flips to the other requester when a response handshake completes.
module exu_rr_arb2 (
   input  logic clock,
   input  logic reset,
   input  logic i_idle,
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_upd,
   input  logic i_upd_owner,
   output logic o_ready0,
   output logic o_ready1
);

   logic r_prio;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_prio <= 1'b0;
      end else if (i_upd) begin
         r_prio <= ~i_upd_owner;
      end
   end

   // a lone requester wins regardless of priority
   assign o_ready0 = i_idle & (~r_prio | ~i_valid1);
   assign o_ready1 = i_idle & ( r_prio | ~i_valid0);

endmodule

// File: rtl/exu_alu_arbiter.sv
// Shares one multi-cycle ALU/CSR datapath between two requesters (round-robin, one op in flight).
// Optional WAIT-state watchdog enabled by defining EXU_ALU_ARB_WATCHDOG_EN.
module exu_alu_arbiter
   import exu_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned OP_W        = OP_W_DEF,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [DATA_W-1:0] req0_csr,
   input  logic [DATA_W-1:0] req1_csr,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   input  logic              rsp0_ready,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_rd,
   output logic [DATA_W-1:0] rsp_csr_wdata,
   output logic              rsp_err,
   output logic              alu_start,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] alu_csr,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_csr_wdata
);

   state_t              r_state;
   logic                r_owner;
   logic                r_start;
   logic                r_rsp0;
   logic                r_rsp1;
   logic                r_err;
   logic [OP_W-1:0]     r_op;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [DATA_W-1:0]   r_csr;
   logic [DATA_W-1:0]   r_rd;
   logic [DATA_W-1:0]   r_wdata;

   logic w_ready0;
   logic w_ready1;
   logic w_acc0;
   logic w_acc1;
   logic w_hs;

`ifdef EXU_ALU_ARB_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] r_wd_cnt;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

   exu_rr_arb2 u_arb (
      .clock       (clock),
      .reset       (reset),
      .i_idle      (r_state == IDLE),
      .i_valid0    (req0_valid),
      .i_valid1    (req1_valid),
      .i_upd       (w_hs),
      .i_upd_owner (r_owner),
      .o_ready0    (w_ready0),
      .o_ready1    (w_ready1)
   );

   assign w_acc0 = req0_valid & w_ready0;
   assign w_acc1 = req1_valid & w_ready1;
   assign w_hs   = (r_rsp0 & rsp0_ready) | (r_rsp1 & rsp1_ready);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_start <= 1'b0;
         r_rsp0  <= 1'b0;
         r_rsp1  <= 1'b0;
         r_err   <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_csr   <= '0;
         r_rd    <= '0;
         r_wdata <= '0;
`ifdef EXU_ALU_ARB_WATCHDOG_EN
         r_wd_cnt <= '0;
`endif
      end else begin
         r_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_acc0 | w_acc1) begin
                  r_op    <= w_acc1 ? req1_op  : req0_op;
                  r_a     <= w_acc1 ? req1_a   : req0_a;
                  r_b     <= w_acc1 ? req1_b   : req0_b;
                  r_csr   <= w_acc1 ? req1_csr : req0_csr;
                  r_owner <= w_acc1;
                  r_start <= 1'b1;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef EXU_ALU_ARB_WATCHDOG_EN
               r_wd_cnt <= '0;
`endif
               r_state <= WAIT;
            end
            WAIT: begin
               // alu_done takes precedence over a same-cycle timeout
               if (alu_done) begin
                  r_rd    <= alu_rd;
                  r_wdata <= alu_csr_wdata;
                  r_err   <= 1'b0;
                  r_rsp0  <= ~r_owner;
                  r_rsp1  <= r_owner;
                  r_state <= RESP;
               end
`ifdef EXU_ALU_ARB_WATCHDOG_EN
               else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                  r_rd    <= '0;
                  r_wdata <= '0;
                  r_err   <= 1'b1;
                  r_rsp0  <= ~r_owner;
                  r_rsp1  <= r_owner;
                  r_state <= RESP;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               if (w_hs) begin
                  r_rsp0  <= 1'b0;
                  r_rsp1  <= 1'b0;
                  r_err   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req0_ready    = w_ready0;
   assign req1_ready    = w_ready1;
   assign rsp0_valid    = r_rsp0;
   assign rsp1_valid    = r_rsp1;
   assign rsp_rd        = r_rd;
   assign rsp_csr_wdata = r_wdata;
   assign rsp_err       = r_err;
   assign alu_start     = r_start;
   assign alu_op        = r_op;
   assign alu_a         = r_a;
   assign alu_b         = r_b;
   assign alu_csr       = r_csr;

endmodule

// File: tb/tb_exu_alu_arbiter.sv
// Directed self-checking bench for exu_alu_arbiter; watchdog steps run when EXU_ALU_ARB_WATCHDOG_EN is defined.
module tb_exu_alu_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [1:0]  req0_op, req1_op, alu_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b, req0_csr, req1_csr;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, rsp_err;
   logic [31:0] rsp_rd, rsp_csr_wdata;
   logic        alu_start, alu_done;
   logic [31:0] alu_a, alu_b, alu_csr, alu_rd, alu_csr_wdata;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   exu_alu_arbiter #(.DATA_W(32), .OP_W(2), .TIMEOUT_CYC(16)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_csr(req0_csr), .req1_csr(req1_csr),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_rd(rsp_rd), .rsp_csr_wdata(rsp_csr_wdata), .rsp_err(rsp_err),
      .alu_start(alu_start), .alu_op(alu_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_csr(alu_csr),
      .alu_done(alu_done), .alu_rd(alu_rd), .alu_csr_wdata(alu_csr_wdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op = '0; req1_op = '0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      req0_csr = '0; req1_csr = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      alu_done = 1'b0; alu_rd = '0; alu_csr_wdata = '0;
      cyc();
      cyc();
      reset = 1'b0;

      // reset state
      chk("rst_ready0", req0_ready, 1);
      chk("rst_ready1", req1_ready, 1);
      chk("rst_rsp0", rsp0_valid, 0);
      chk("rst_rsp1", rsp1_valid, 0);
      chk("rst_start", alu_start, 0);
      chk("rst_rd", rsp_rd, 0);
      chk("rst_err", rsp_err, 0);

      // single request: op=1 a=5 b=7, result 12
      req0_valid = 1'b1; req0_op = 2'd1; req0_a = 32'd5; req0_b = 32'd7; req0_csr = 32'd3;
      #1;
      chk("t1_ready0", req0_ready, 1);
      cyc();
      req0_valid = 1'b0;
      chk("t1_start", alu_start, 1);
      chk("t1_op", alu_op, 1);
      chk("t1_a", alu_a, 5);
      chk("t1_b", alu_b, 7);
      chk("t1_csr", alu_csr, 3);
      chk("t1_ready0_busy", req0_ready, 0);
      cyc();
      chk("t1_start_pulse", alu_start, 0);
      chk("t1_rsp0_early", rsp0_valid, 0);
      alu_done = 1'b1; alu_rd = 32'd12; alu_csr_wdata = 32'h55;
      cyc();
      alu_done = 1'b0;
      chk("t1_rsp0", rsp0_valid, 1);
      chk("t1_rsp1", rsp1_valid, 0);
      chk("t1_rd", rsp_rd, 12);
      chk("t1_wdata", rsp_csr_wdata, 32'h55);
      chk("t1_a_hold", alu_a, 5);
      rsp0_ready = 1'b1;
      cyc();
      rsp0_ready = 1'b0;
      chk("t1_rsp0_clear", rsp0_valid, 0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("t1_prio_ready0", req0_ready, 0);
      chk("t1_prio_ready1", req1_ready, 1);
      req0_valid = 1'b0; req1_valid = 1'b0;

`ifdef EXU_ALU_ARB_WATCHDOG_EN
      // timeout with no alu_done: RESP after 16 WAIT cycles
      req0_valid = 1'b1;
      cyc();
      req0_valid = 1'b0;
      cyc();
      repeat (15) cyc();
      chk("wd_not_yet", rsp0_valid, 0);
      cyc();
      chk("wd_rsp0", rsp0_valid, 1);
      chk("wd_err", rsp_err, 1);
      chk("wd_rd", rsp_rd, 0);
      chk("wd_wdata", rsp_csr_wdata, 0);
      rsp0_ready = 1'b1;
      cyc();
      rsp0_ready = 1'b0;
      chk("wd_err_clear", rsp_err, 0);
      // alu_done on the 16th WAIT cycle beats the timeout
      req0_valid = 1'b1;
      cyc();
      req0_valid = 1'b0;
      cyc();
      repeat (15) cyc();
      alu_done = 1'b1; alu_rd = 32'd77; alu_csr_wdata = 32'd66;
      cyc();
      alu_done = 1'b0;
      chk("wd_race_rsp0", rsp0_valid, 1);
      chk("wd_race_err", rsp_err, 0);
      chk("wd_race_rd", rsp_rd, 77);
      rsp0_ready = 1'b1;
      cyc();
      rsp0_ready = 1'b0;
`endif

      // simultaneous requests after reset: grants 0,1,0,1 at 4-cycle spacing
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_op = 2'd2; req0_a = 32'd100; req0_b = 32'd101; req0_csr = 32'd102;
      req1_op = 2'd3; req1_a = 32'd200; req1_b = 32'd201; req1_csr = 32'd202;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_ready0", req0_ready, (k % 2 == 0));
         chk("rr_ready1", req1_ready, (k % 2 == 1));
         cyc();
         chk("rr_start", alu_start, 1);
         chk("rr_a", alu_a, (k % 2 == 0) ? 32'd100 : 32'd200);
         cyc();
         alu_done = 1'b1; alu_rd = 32'd1000 + 32'(k);
         cyc();
         alu_done = 1'b0;
         chk("rr_rsp0", rsp0_valid, (k % 2 == 0));
         chk("rr_rsp1", rsp1_valid, (k % 2 == 1));
         chk("rr_rd", rsp_rd, 32'd1000 + 32'(k));
         cyc();
      end

      // response backpressure on requester 1
      req0_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
      chk("bp_ready1", req1_ready, 1);
      cyc();
      req0_valid = 1'b1;
      cyc();
      alu_done = 1'b1; alu_rd = 32'hABC;
      cyc();
      alu_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp1", rsp1_valid, 1);
         chk("bp_rd", rsp_rd, 32'hABC);
         chk("bp_ready0", req0_ready, 0);
         chk("bp_start", alu_start, 0);
         cyc();
      end
      rsp1_ready = 1'b1;
      cyc();
      rsp1_ready = 1'b0;
      chk("bp_rsp1_clear", rsp1_valid, 0);
      chk("bp_ready0_idle", req0_ready, 1);
      chk("bp_ready1_idle", req1_ready, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // reset while in WAIT, then a late alu_done
      req0_valid = 1'b1; req0_a = 32'd9;
      cyc();
      req0_valid = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      alu_done = 1'b1; alu_rd = 32'hBAD;
      chk("rw_start", alu_start, 0);
      chk("rw_rsp0", rsp0_valid, 0);
      chk("rw_ready0", req0_ready, 1);
      cyc();
      alu_done = 1'b0;
      chk("rw_late_rsp0", rsp0_valid, 0);
      chk("rw_late_rsp1", rsp1_valid, 0);
      chk("rw_late_rd", rsp_rd, 0);
      chk("rw_late_ready0", req0_ready, 1);

      // stray alu_done in IDLE
      alu_done = 1'b1; alu_rd = 32'hDEAD;
      cyc();
      alu_done = 1'b0;
      chk("stray_rsp0", rsp0_valid, 0);
      chk("stray_rsp1", rsp1_valid, 0);
      chk("stray_rd", rsp_rd, 0);
      chk("stray_ready0", req0_ready, 1);
      chk("stray_start", alu_start, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
